// File: rtl/sortn_pipe.sv
// Pipelined N-element unsigned sorter built from an odd-even transposition network.
// One compare-exchange layer per registered stage; the whole pipe stalls on output backpressure.
module sortn_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM        = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH*NUM-1:0]  in_data,
  input  logic                       in_desc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*NUM-1:0]  out_data,
  output logic                       out_desc,
  output logic                       busy
);

  localparam int VW = DATA_WIDTH * NUM;
  typedef logic [VW-1:0] vec_t;

  if (NUM < 2) begin : g_bad_num
    $error("sortn_pipe: NUM must be >= 2");
  end

  // One network layer: pairs start at index (k mod 2); unpaired elements pass through.
  function automatic vec_t cx_stage(input vec_t v, input logic desc, input int k);
    vec_t                  r;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    r = v;
    for (int i = k % 2; i + 1 < NUM; i += 2) begin
      a = v[DATA_WIDTH*i +: DATA_WIDTH];
      b = v[DATA_WIDTH*(i+1) +: DATA_WIDTH];
      if (desc ? (a < b) : (a > b)) begin
        r[DATA_WIDTH*i +: DATA_WIDTH]     = b;
        r[DATA_WIDTH*(i+1) +: DATA_WIDTH] = a;
      end
    end
    return r;
  endfunction

  logic [NUM-1:0] vld_q;
  logic [NUM-1:0] vld_d;
  logic [NUM-1:0] desc_q;
  logic [NUM-1:0] desc_d;
  vec_t           data_q [NUM];
  vec_t           data_d [NUM];
  logic           advance;

  assign advance = !vld_q[NUM-1] || out_ready;

  assign vld_d  = {vld_q[NUM-2:0], in_valid};
  assign desc_d = {desc_q[NUM-2:0], in_desc};

  for (genvar k = 0; k < NUM; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign data_d[k] = cx_stage(in_data, in_desc, k);
    end else begin : g_next
      assign data_d[k] = cx_stage(data_q[k-1], desc_q[k-1], k);
    end
  end

  // Stage registers S0..S(NUM-1); all advance together or all hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      desc_q <= '0;
      for (int k = 0; k < NUM; k++) begin
        data_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q  <= vld_d;
      desc_q <= desc_d;
      for (int k = 0; k < NUM; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = vld_q[NUM-1];
  assign out_data  = data_q[NUM-1];
  assign out_desc  = desc_q[NUM-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_sortn_pipe.sv
// Scoreboard bench for sortn_pipe: directed checks on a 4x8 instance plus a random
// sweep over several NUM/DATA_WIDTH instances, all compared against a queue-sort model.
module tb_sortn_pipe;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks;
  int failures;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_desc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_desc;
  logic        busy;

  logic sw_rst_n;
  logic sw_go;
  int   sw_left;

  sortn_pipe #(.DATA_WIDTH(8), .NUM(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_desc   (in_desc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_desc  (out_desc),
    .busy      (busy)
  );

  // Reference: unpack n elements of w bits, sort them as numbers, repack.
  function automatic logic [127:0] ref_sort(input logic [127:0] d, input int n, input int w,
                                            input logic desc);
    int unsigned  q[$];
    logic [127:0] mask;
    logic [127:0] r;
    logic [127:0] t;
    mask = (128'd1 << w) - 128'd1;
    for (int i = 0; i < n; i++) begin
      t = (d >> (w * i)) & mask;
      q.push_back(t[31:0]);
    end
    if (desc) q.rsort();
    else      q.sort();
    r = '0;
    for (int i = 0; i < n; i++) begin
      r = r | (128'(q[i]) << (w * i));
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [128:0] m_exp[$];

  // Monitor for the directed instance: output pops, stall stability, input pushes.
  initial begin : mon_main
    logic [128:0] e;
    logic         stall;
    logic [31:0]  hd;
    logic         hs;
    stall = 1'b0;
    hd    = '0;
    hs    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_exp.delete();
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("main_stall_valid", 128'(out_valid), 128'(1));
          chk("main_stall_data", 128'(out_data), 128'(hd));
          chk("main_stall_desc", 128'(out_desc), 128'(hs));
        end
        if (out_valid && out_ready) begin
          if (m_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL main_unexpected actual=%0h required=no_output", out_data);
          end else begin
            e = m_exp.pop_front();
            chk("main_data", 128'(out_data), 128'(e[31:0]));
            chk("main_desc", 128'(out_desc), 128'(e[128]));
          end
        end
        stall = out_valid && !out_ready;
        hd    = out_data;
        hs    = out_desc;
        if (in_valid && in_ready)
          m_exp.push_back({in_desc, ref_sort(128'(in_data), 4, 8, in_desc)});
      end
    end
  end

  for (genvar ni = 0; ni < 4; ni++) begin : g_n
    for (genvar wi = 0; wi < 3; wi++) begin : g_w
      localparam int N = (ni == 0) ? 2 : (ni == 1) ? 3 : (ni == 2) ? 5 : 8;
      localparam int W = (wi == 0) ? 1 : (wi == 1) ? 8 : 16;

      logic           iv = 1'b0;
      logic           ir;
      logic           ov;
      logic           ordy = 1'b1;
      logic           idsc = 1'b0;
      logic           odsc;
      logic           bsy;
      logic [W*N-1:0] id = '0;
      logic [W*N-1:0] od;
      logic [128:0]   q[$];

      sortn_pipe #(.DATA_WIDTH(W), .NUM(N)) u_sw (
        .clk       (clk),
        .rst_n     (sw_rst_n),
        .in_valid  (iv),
        .in_ready  (ir),
        .in_data   (id),
        .in_desc   (idsc),
        .out_valid (ov),
        .out_ready (ordy),
        .out_data  (od),
        .out_desc  (odsc),
        .busy      (bsy)
      );

      initial begin : drv
        logic [127:0] r;
        wait (sw_go);
        tick();
        for (int k = 0; k < 1000; k++) begin
          r    = {$urandom(), $urandom(), $urandom(), $urandom()};
          iv   = ($urandom_range(0, 3) != 0);
          id   = r[W*N-1:0];
          idsc = ($urandom_range(0, 1) != 0);
          ordy = ($urandom_range(0, 3) != 0);
          tick();
        end
        iv   = 1'b0;
        ordy = 1'b1;
        for (int k = 0; k < 40 && (q.size() != 0 || bsy); k++) tick();
        chk($sformatf("sw_n%0d_w%0d_drain", N, W), 128'(q.size()), 128'(0));
        chk($sformatf("sw_n%0d_w%0d_idle", N, W), 128'(bsy), 128'(0));
        sw_left--;
      end

      initial begin : mon
        logic [128:0]   e;
        logic           stall;
        logic [W*N-1:0] hd;
        logic           hs;
        stall = 1'b0;
        hd    = '0;
        hs    = 1'b0;
        forever begin
          @(negedge clk);
          if (!sw_rst_n) begin
            q.delete();
            stall = 1'b0;
          end else begin
            if (stall) begin
              chk($sformatf("sw_n%0d_w%0d_stall_data", N, W), 128'(od), 128'(hd));
              chk($sformatf("sw_n%0d_w%0d_stall_desc", N, W), 128'(odsc), 128'(hs));
            end
            if (ov && ordy) begin
              if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sw_n%0d_w%0d_unexpected actual=%0h required=no_output", N, W, od);
              end else begin
                e = q.pop_front();
                chk($sformatf("sw_n%0d_w%0d_data", N, W), 128'(od), 128'(e[W*N-1:0]));
                chk($sformatf("sw_n%0d_w%0d_desc", N, W), 128'(odsc), 128'(e[128]));
              end
            end
            stall = ov && !ordy;
            hd    = od;
            hs    = odsc;
            if (iv && ir) q.push_back({idsc, ref_sort(128'(id), N, W, idsc)});
          end
        end
      end
    end
  end

  task automatic send_wait(input logic [31:0] d, input logic ds, input logic [31:0] exp,
                           input string nm);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = ds;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, 128'(n), 128'(4));
    chk({nm, "_data"}, 128'(out_data), 128'(exp));
    chk({nm, "_desc"}, 128'(out_desc), 128'(ds));
    tick();
  endtask

  initial begin : main
    int          s;
    int          c;
    logic        acc;
    logic [3:0]  pat;
    logic        expv;
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    sw_rst_n  = 1'b0;
    sw_go     = 1'b0;
    sw_left   = 12;
    in_valid  = 1'b0;
    in_data   = '0;
    in_desc   = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_data", 128'(out_data), 128'(0));
    chk("reset_out_desc", 128'(out_desc), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    tick();
    tick();
    rst_n    = 1'b1;
    sw_rst_n = 1'b1;
    tick();

    send_wait(32'h20401030, 1'b0, 32'h40302010, "asc_basic");
    send_wait(32'h807FFF00, 1'b1, 32'h007F80FF, "desc_extremes");
    send_wait(32'hAAAAAAAA, 1'b1, 32'hAAAAAAAA, "desc_equal");
    send_wait(32'hAAAAAAAA, 1'b0, 32'hAAAAAAAA, "asc_equal");

    // Back-to-back stream with alternating direction.
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 8);
      in_data  = $urandom();
      in_desc  = (i % 2 == 1);
      tick();
      chk($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(i >= 3 && i < 11));
    end
    in_valid = 1'b0;

    // Backpressure window while streaming ten vectors.
    s = 0;
    c = 0;
    in_data = $urandom();
    in_desc = ($urandom_range(0, 1) != 0);
    while ((s < 10 || busy) && c < 80) begin
      out_ready = !(c >= 5 && c < 11);
      in_valid  = (s < 10);
      #1;
      if (out_valid && !out_ready) chk("bp_in_ready_low", 128'(in_ready), 128'(0));
      acc = in_valid && in_ready;
      tick();
      c++;
      if (acc) begin
        s++;
        in_data = $urandom();
        in_desc = ($urandom_range(0, 1) != 0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_all_sent", 128'(s), 128'(10));
    chk("bp_drained", 128'(busy), 128'(0));

    // Bubbles: valid pattern 1,0,1,0 reappears four cycles later.
    pat = 4'b0101;
    for (int i = 0; i < 8; i++) begin
      in_valid = (i < 4) ? pat[i] : 1'b0;
      in_data  = $urandom();
      in_desc  = 1'b0;
      tick();
      expv = 1'b0;
      if (i >= 3 && i < 7) expv = pat[i-3];
      chk($sformatf("bubble_valid_%0d", i), 128'(out_valid), 128'(expv));
      if (i == 5) chk("bubble_busy_last", 128'(busy), 128'(1));
      if (i == 6) chk("bubble_busy_fall", 128'(busy), 128'(0));
    end

    // Asynchronous reset with three vectors in flight and the output stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom();
      in_desc  = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("rst_pre_valid", 128'(out_valid), 128'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_desc", 128'(out_desc), 128'(0));
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    send_wait(32'h01090305, 1'b0, 32'h09050301, "post_reset");
    chk("post_reset_empty", 128'(out_valid), 128'(0));

    // Random sweep over the other configurations.
    sw_go = 1'b1;
    c = 0;
    while (sw_left != 0 && c < 20000) begin
      tick();
      c++;
    end
    chk("sweep_complete", 128'(sw_left), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sortn_pipe.md
Name: sortn_pipe

Overview:
- Pipelined, parametrised unsigned sorter for NUM elements of DATA_WIDTH bits each.
- Generalises the two-element combinational sort to an N-element odd-even transposition network.
- Every stage is registered. Ascending/descending order is selected per transaction.
- Sits between a valid/ready producer and consumer, e.g. median/rank filters and top-K selection. Accepts one vector per cycle when unstalled.

Parameters:
- DATA_WIDTH, 8, width of each unsigned element.
- NUM, 4, number of elements per vector. Legal values: NUM >= 2; any other value is illegal and elaboration must fail.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, in_data/in_desc valid this cycle.
- in_ready, output, 1, block can accept this cycle.
- in_data, input, DATA_WIDTH*NUM, packed vector; element i = in_data[DATA_WIDTH*i +: DATA_WIDTH].
- in_desc, input, 1, 0 = ascending, 1 = descending; sampled with in_data.
- out_valid, output, 1, out_data holds a sorted vector.
- out_ready, input, 1, consumer accepts this cycle.
- out_data, output, DATA_WIDTH*NUM, sorted vector, same packing as in_data.
- out_desc, output, 1, in_desc carried alongside the vector.
- busy, output, 1, OR of all stage valid bits.

Behaviour:
- Reset: asynchronous on rst_n low.
  - All stage valid bits, stage data and stage desc registers are cleared to 0.
  - Resulting outputs: out_valid=0, out_data=0, out_desc=0, busy=0, in_ready=1.
  - Reset mid-operation discards all in-flight vectors; nothing is replayed.
- Pipeline: NUM register stages, S0..S(NUM-1). S(NUM-1) drives out_valid, out_data and out_desc directly.
- Stage k logic: compare-exchange on pairs (i, i+1).
  - Pairs start at i=0 when k is even and at i=1 when k is odd, stepping by 2, for every i with i+1 < NUM.
  - Elements not in any pair pass through unchanged.
- Compare-exchange direction:
  - Ascending (desc=0): after exchange, element i <= element i+1. Largest value ends at the highest index, i.e. the top bits.
  - Descending (desc=1): after exchange, element i >= element i+1.
  - Each stage uses the desc bit travelling with its own vector.
  - Equal values are never swapped.
  - Comparison is unsigned at full DATA_WIDTH; element values are never modified, only moved.
- Advance condition: advance = !out_valid || out_ready.
  - in_ready = advance (combinational from out_valid/out_ready; no combinational path from in_valid).
  - When advance=1, every stage loads from its predecessor. S0 loads the network output of in_data with valid = in_valid.
  - When advance=0, all stages hold their contents.
- Latency and throughput:
  - Latency is exactly NUM cycles from the in_valid&&in_ready edge to out_valid, with no stalls.
  - Throughput is one vector per cycle while out_ready=1.
- Bubbles: invalid slots propagate as bubbles and are not compacted.
  - The data registers of a bubble slot still update; their value is don't-care.
  - out_data is only meaningful while out_valid=1.
- Handshakes:
  - Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
  - Simultaneous input and output transfer in the same cycle is legal and loses nothing.
  - While stalled (out_valid=1, out_ready=0): out_data/out_desc are held stable and in_ready=0.
- Ordering: vectors leave in acceptance order. No vector is dropped or duplicated.
- busy = 1 whenever any stage valid bit is set.

Test Plan:
- NUM=4, W=8, ascending: in_data elements [e0..e3] = [0x30,0x10,0x40,0x20] with out_ready=1 -> after exactly 4 cycles, out_valid=1 and out_data elements = [0x10,0x20,0x30,0x40], i.e. out_data=0x40302010.
- Descending with extremes: input [0x00,0xFF,0x7F,0x80], in_desc=1 -> output elements [0xFF,0x80,0x7F,0x00], out_desc=1. Repeat with all-equal 0xAA -> output unchanged.
- Back-to-back streaming: 8 consecutive vectors with alternating desc, out_ready=1 -> 8 outputs on consecutive cycles starting cycle 4, each correctly sorted per its own desc, in order.
- Backpressure: hold out_ready=0 for 6 cycles while streaming -> in_ready falls once out_valid=1, out_data stable throughout, no loss. Release -> remaining vectors drain in order.
- Bubbles: in_valid pattern 1,0,1,0 -> out_valid pattern 1,0,1,0 delayed by 4 cycles. busy falls 1 cycle after the last vector is accepted out.
- Reset mid-stream: assert rst_n=0 asynchronously with 3 vectors in flight -> out_valid and busy drop immediately, out_data=0. After release, a fresh vector emerges after 4 cycles with no stale data.
- Sweep: NUM in {2,3,5,8}, W in {1,8,16}, 1000 random vectors each, checked against a reference sort model.
